// File: rtl/hz_tag_pipe.sv
// Hazard-unit tag pipeline: carries the register tags of issued instructions through EX, MEM and WB.
// It also counts the bubbles that hazard stalls and flushes force into EX.
module hz_tag_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_iss_i,
  input  logic [4:0]       rs_iss_i,
  input  logic [4:0]       rt_iss_i,
  input  logic [4:0]       rd_iss_i,
  input  logic             reg_wr_iss_i,
  input  logic             mem_to_reg_iss_i,
  input  logic             stall_iss_hz_i,
  input  logic             flush_ex_hz_i,
  output logic             issue_ack_o,
  output logic [4:0]       rs_ex_mem_hz_o,
  output logic [4:0]       rt_ex_mem_hz_o,
  output logic             mem_to_reg_ex_mem_hz_o,
  output logic [4:0]       rd_mem_wb_hz_o,
  output logic             reg_wr_mem_wb_hz_o,
  output logic [4:0]       rd_wb_ret_hz_o,
  output logic             reg_wr_wb_ret_hz_o,
  output logic             valid_ex_o,
  output logic             valid_mem_o,
  output logic             valid_wb_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [4:0] rd_ex;
  logic       reg_wr_ex;
  logic       hz_bubble;

  assign issue_ack_o = valid_iss_i & ~stall_iss_hz_i & ~flush_ex_hz_i;
  // Only bubbles caused by a hazard are counted; idle issue slots are not.
  assign hz_bubble   = ~issue_ack_o & (stall_iss_hz_i | flush_ex_hz_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_ex_o             <= 1'b0;
      rs_ex_mem_hz_o         <= 5'd0;
      rt_ex_mem_hz_o         <= 5'd0;
      rd_ex                  <= 5'd0;
      reg_wr_ex              <= 1'b0;
      mem_to_reg_ex_mem_hz_o <= 1'b0;
    end else if (issue_ack_o) begin
      valid_ex_o             <= 1'b1;
      rs_ex_mem_hz_o         <= rs_iss_i;
      rt_ex_mem_hz_o         <= rt_iss_i;
      rd_ex                  <= rd_iss_i;
      // A write to r0 is dropped here so it can never match a forwarding compare.
      reg_wr_ex              <= reg_wr_iss_i & (rd_iss_i != 5'd0);
      mem_to_reg_ex_mem_hz_o <= mem_to_reg_iss_i;
    end else begin
      valid_ex_o             <= 1'b0;
      rs_ex_mem_hz_o         <= 5'd0;
      rt_ex_mem_hz_o         <= 5'd0;
      rd_ex                  <= 5'd0;
      reg_wr_ex              <= 1'b0;
      mem_to_reg_ex_mem_hz_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mem_o        <= 1'b0;
      rd_mem_wb_hz_o     <= 5'd0;
      reg_wr_mem_wb_hz_o <= 1'b0;
      valid_wb_o         <= 1'b0;
      rd_wb_ret_hz_o     <= 5'd0;
      reg_wr_wb_ret_hz_o <= 1'b0;
    end else begin
      valid_mem_o        <= valid_ex_o;
      rd_mem_wb_hz_o     <= rd_ex;
      reg_wr_mem_wb_hz_o <= reg_wr_ex;
      valid_wb_o         <= valid_mem_o;
      rd_wb_ret_hz_o     <= rd_mem_wb_hz_o;
      reg_wr_wb_ret_hz_o <= reg_wr_mem_wb_hz_o;
    end
  end

  // Saturating counter: holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_o <= '0;
    end else if (hz_bubble && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/hz_tag_pipe.md
HZ_TAG_PIPE -- requirements
Module: hz_tag_pipe

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the bubble counter (legal range 4..32).
REQ-002 The ports SHALL be:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_iss_i  input  1  issue stage holds a real instruction.
- rs_iss_i  input  5  issue-stage source register 1.
- rt_iss_i  input  5  issue-stage source register 2.
- rd_iss_i  input  5  issue-stage destination register.
- reg_wr_iss_i  input  1  issue-stage instruction writes rd.
- mem_to_reg_iss_i  input  1  issue-stage instruction is a load.
- stall_iss_hz_i  input  1  hazard stall of issue stage.
- flush_ex_hz_i  input  1  hazard flush of EX stage.
- issue_ack_o  output  1  issue-stage instruction accepted into EX this cycle.
- rs_ex_mem_hz_o  output  5  EX-stage rs tag.
- rt_ex_mem_hz_o  output  5  EX-stage rt tag.
- mem_to_reg_ex_mem_hz_o  output  1  EX-stage load flag.
- rd_mem_wb_hz_o  output  5  MEM-stage destination tag.
- reg_wr_mem_wb_hz_o  output  1  MEM-stage write-enable tag.
- rd_wb_ret_hz_o  output  5  WB-stage destination tag.
- reg_wr_wb_ret_hz_o  output  1  WB-stage write-enable tag.
- valid_ex_o, valid_mem_o, valid_wb_o  output  1 each  stage occupancy.
- bubble_cnt_o  output  CNT_W  bubbles inserted since reset.

Function
REQ-003 The block SHALL hold three tag stages EX, MEM, WB; EX holds {valid, rs, rt, rd, reg_wr, mem_to_reg}; MEM and WB hold {valid, rd, reg_wr}.
REQ-004 issue_ack_o SHALL equal valid_iss_i & ~stall_iss_hz_i & ~flush_ex_hz_i, combinationally.
REQ-005 On each edge with issue_ack_o=1, EX SHALL load the issue tags with valid=1.
REQ-006 On each edge with issue_ack_o=0, EX SHALL load a bubble: valid=0, rs=rt=rd=0, reg_wr=0, mem_to_reg=0.
REQ-007 flush_ex_hz_i SHALL take priority over stall_iss_hz_i; both asserted still yields exactly one bubble per cycle.
REQ-008 MEM SHALL load {valid, rd, reg_wr} from EX and WB SHALL load from MEM on every non-reset edge; MEM and WB never stall.
REQ-009 Latency: a tag accepted at edge N SHALL appear on EX outputs after edge N, MEM outputs after N+1, WB outputs after N+2, and leave WB after N+3.
REQ-010 The reg_wr value captured into EX SHALL be reg_wr_iss_i & (rd_iss_i != 0); writes to register 0 never produce a forwarding match.
REQ-011 Every output reg_wr tag SHALL be 0 whenever its stage valid is 0.
REQ-012 bubble_cnt_o SHALL increment by 1 on each edge where a bubble loads into EX while stall_iss_hz_i | flush_ex_hz_i = 1; idle bubbles (valid_iss_i=0, no stall/flush) SHALL NOT count.
REQ-013 bubble_cnt_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 All outputs except issue_ack_o SHALL be driven directly from flops.

Reset
REQ-015 With reset=1 at an edge, all stage fields, all valid bits and bubble_cnt_o SHALL become 0, overriding every other input.
REQ-016 Reset asserted mid-flight SHALL discard all in-flight tags; the first instruction accepted after reset deassertion SHALL follow REQ-009 timing exactly.
REQ-017 issue_ack_o SHALL remain combinational during reset; RTL SHALL ignore its value while reset=1.

Verification
REQ-018 Single issue: rd_iss=5, reg_wr=1, one cycle -> rd_mem_wb_hz_o=5 with reg_wr=1 one cycle after EX, rd_wb_ret_hz_o=5 next cycle, then all zero.
REQ-019 Back-to-back issue rd=1,2,3 -> WB shows 1,2,3 on consecutive cycles; bubble_cnt_o stays 0.
REQ-020 stall_iss_hz_i held 3 cycles with valid_iss_i=1 -> issue_ack_o=0, three bubbles in EX, bubble_cnt_o=3; instruction enters EX on the 4th edge.
REQ-021 stall and flush asserted together for 1 cycle -> one bubble, bubble_cnt_o increments by exactly 1.
REQ-022 rd_iss=0 with reg_wr_iss=1 -> reg_wr_mem_wb_hz_o and reg_wr_wb_ret_hz_o stay 0 while valid_mem_o/valid_wb_o pulse 1.
REQ-023 CNT_W=4, 20 consecutive stall cycles -> bubble_cnt_o reaches 15 and holds; reset mid-pipeline -> all outputs 0 after the reset edge.
